// File: rtl/alu_exec_unit_pkg.sv
// alu_pkg: ALU control codes, execute FSM states and widths
// shared by the ALU control decoder and the execute unit.
package alu_pkg;

  localparam int ALU_WIDTH = 64;
  localparam int ALU_SHW   = 6;

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_ORR   = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_MUL   = 3'b011;
  localparam logic [2:0] ALU_LSL   = 3'b100;
  localparam logic [2:0] ALU_LSR   = 3'b101;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2,
    ST_DONE  = 2'd3
  } alu_state_e;

  function automatic logic is_shift(
    input logic [2:0] ctl
  );
    return (ctl == ALU_LSL) ||
           (ctl == ALU_LSR);
  endfunction

endpackage

// File: rtl/alu_exec_unit_mul_shift_add.sv
// mul_shift_add: fixed-latency iterative unsigned multiplier,
// one partial product per cycle, low WIDTH bits kept.
module mul_shift_add
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             run;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;

  // Start cycle already folds in bit 0, so WIDTH edges total.
  assign product = mplier[0] ? acc + mcand : acc;
  assign done    = run && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run    <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= CW'(1);
      acc    <= b[0] ? a : '0;
      mcand  <= a << 1;
      mplier <= b >> 1;
    end else if (run) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) begin
        run <= 1'b0;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshake,
// single-cycle logic/add/sub, serial shifts and iterative multiply.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SHW   = ALU_SHW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             busy
);

  alu_state_e state;

  logic             accept;
  logic             shift_op;
  logic             lsl_op;
  logic             multi;
  logic             mul_go;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_nxt;
  logic [WIDTH-1:0] sh1;
  logic [SHW-1:0]   sh_cnt;
  logic             sh_left;

  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;

  logic             ld;
  logic [WIDTH-1:0] res_d;
  logic             c_d;
  logic             v_d;

  assign in_ready = (state == ST_IDLE) &&
                    (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == ST_SHIFT) ||
                    (state == ST_MUL);

  assign shift_op = is_shift(alu_ctl);
  assign lsl_op   = (alu_ctl == ALU_LSL);
  assign mul_go   = accept && (alu_ctl == ALU_MUL);
  assign multi    = (alu_ctl == ALU_MUL) ||
                    (shift_op && (shamt > SHW'(1)));

  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} + {1'b0, ~b} +
                 {{WIDTH{1'b0}}, 1'b1};

  // Shifts of 0 or 1 finish in the accept cycle.
  assign sh1    = !shamt[0] ? a :
                  lsl_op    ? a << 1 : a >> 1;
  assign sh_nxt = sh_left ? sh_q << 1 : sh_q >> 1;

  mul_shift_add #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (mul_go),
    .a      (a),
    .b      (b),
    .done   (mul_done),
    .product(mul_product)
  );

  always_comb begin
    ld    = 1'b0;
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept && !multi) begin
          ld = 1'b1;
          unique case (alu_ctl)
            ALU_AND: res_d = a & b;
            ALU_ORR: res_d = a | b;
            ALU_ADD: begin
              res_d = add_w[WIDTH-1:0];
              c_d   = add_w[WIDTH];
              v_d   = (a[WIDTH-1] == b[WIDTH-1]) &&
                      (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
              res_d = sub_w[WIDTH-1:0];
              c_d   = sub_w[WIDTH];
              v_d   = (a[WIDTH-1] != b[WIDTH-1]) &&
                      (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_LSL, ALU_LSR: res_d = sh1;
            default: res_d = b;
          endcase
        end
      end
      ST_SHIFT: begin
        if (sh_cnt == SHW'(1)) begin
          ld    = 1'b1;
          res_d = sh_nxt;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          ld    = 1'b1;
          res_d = mul_product;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      sh_q      <= '0;
      sh_cnt    <= '0;
      sh_left   <= 1'b0;
    end else begin
      if (ld) begin
        result <= res_d;
        flag_n <= res_d[WIDTH-1];
        flag_z <= (res_d == '0);
        flag_c <= c_d;
        flag_v <= v_d;
      end
      unique case (state)
        ST_IDLE: begin
          unique case (1'b1)
            mul_go: begin
              out_valid <= 1'b0;
              state     <= ST_MUL;
            end
            accept && shift_op && multi: begin
              out_valid <= 1'b0;
              state     <= ST_SHIFT;
              sh_q      <= lsl_op ? a << 1 : a >> 1;
              sh_cnt    <= shamt - SHW'(1);
              sh_left   <= lsl_op;
            end
            accept && !multi: out_valid <= 1'b1;
            !accept && out_ready: out_valid <= 1'b0;
            default: ;
          endcase
        end
        ST_SHIFT: begin
          sh_q   <= sh_nxt;
          sh_cnt <= sh_cnt - SHW'(1);
          if (sh_cnt == SHW'(1)) begin
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and random checks of alu_exec_unit
// against an arithmetic reference model.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_ctl;
  logic [63:0] a;
  logic [63:0] b;
  logic [5:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        flag_n, flag_z, flag_c, flag_v;
  logic        busy;

  int checks = 0;
  int errors = 0;

  localparam logic signed [65:0] MAXS =
    (66'sd1 <<< 63) - 66'sd1;
  localparam logic signed [65:0] MINS =
    -(66'sd1 <<< 63);

  typedef struct {
    logic [2:0]  ctl;
    logic [63:0] x;
    logic [63:0] y;
    logic [5:0]  sh;
    logic [63:0] er;
    logic [3:0]  ef;
    int          el;
  } vec_t;

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_ctl  (alu_ctl),
    .a        (a),
    .b        (b),
    .shamt    (shamt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flag_n   (flag_n),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .flag_v   (flag_v),
    .busy     (busy)
  );

  function automatic logic [3:0] nzcv();
    return {flag_n, flag_z, flag_c, flag_v};
  endfunction

  function automatic void model(
    input  logic [2:0]  ctl,
    input  logic [63:0] x,
    input  logic [63:0] y,
    input  logic [5:0]  sh,
    output logic [63:0] r,
    output logic [3:0]  f,
    output int          lat
  );
    logic c, v;
    logic signed [65:0] sx, sy, s;
    c = 1'b0;
    v = 1'b0;
    lat = 1;
    sx = $signed({{2{x[63]}}, x});
    sy = $signed({{2{y[63]}}, y});
    case (ctl)
      ALU_AND: r = x & y;
      ALU_ORR: r = x | y;
      ALU_ADD: begin
        r = x + y;
        c = (r < x);
        s = sx + sy;
        v = (s > MAXS) || (s < MINS);
      end
      ALU_SUB: begin
        r = x - y;
        c = (x >= y);
        s = sx - sy;
        v = (s > MAXS) || (s < MINS);
      end
      ALU_MUL: begin
        r = x * y;
        lat = 64;
      end
      ALU_LSL: begin
        r = x << sh;
        lat = (sh == 0) ? 1 : int'(sh);
      end
      ALU_LSR: begin
        r = x >> sh;
        lat = (sh == 0) ? 1 : int'(sh);
      end
      default: r = y;
    endcase
    f = {r[63], r == 64'd0, c, v};
  endfunction

  task automatic wait_ready(output bit to);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    to = !in_ready;
  endtask

  task automatic scramble();
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    shamt = 6'($urandom);
    alu_ctl = 3'($urandom);
  endtask

  task automatic run_op(
    input  logic [2:0]  ctl,
    input  logic [63:0] x,
    input  logic [63:0] y,
    input  logic [5:0]  sh,
    output logic [63:0] r,
    output logic [3:0]  f,
    output int          lat,
    output bit          to
  );
    r = '0;
    f = '0;
    lat = 0;
    alu_ctl = ctl;
    a = x;
    b = y;
    shamt = sh;
    in_valid = 1'b1;
    wait_ready(to);
    if (to) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    to = !out_valid;
    r = result;
    f = nzcv();
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: out_valid=%b busy=%b want 0 0",
               out_valid, busy);
    end
    checks++;
    if (result !== 64'd0) begin
      errors++;
      $display("FAIL reset_result: got %h want 0", result);
    end
    checks++;
    if (nzcv() !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000", nzcv());
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    vec_t dv[8];
    logic [63:0] r;
    logic [3:0] f;
    int lat;
    bit to;
    dv[0] = '{ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd0,
              64'h8000_0000_0000_0000, 4'b1001, 1};
    dv[1] = '{ALU_SUB, 64'd5, 64'd5, 6'd0,
              64'd0, 4'b0110, 1};
    dv[2] = '{ALU_SUB, 64'd3, 64'd5, 6'd0,
              64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1};
    dv[3] = '{ALU_LSR, 64'h80, 64'd9, 6'd0,
              64'h80, 4'b0000, 1};
    dv[4] = '{ALU_MUL, 64'd7, 64'd6, 6'd0,
              64'd42, 4'b0000, 64};
    dv[5] = '{ALU_MUL, 64'h1_0000_0000, 64'h1_0000_0000, 6'd0,
              64'd0, 4'b0100, 64};
    dv[6] = '{ALU_LSL, 64'd1, 64'd0, 6'd3,
              64'd8, 4'b0000, 3};
    dv[7] = '{ALU_LSL, 64'd1, 64'd0, 6'd63,
              64'h8000_0000_0000_0000, 4'b1000, 63};
    for (int i = 0; i < 8; i++) begin
      run_op(dv[i].ctl, dv[i].x, dv[i].y, dv[i].sh,
             r, f, lat, to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL dir[%0d] timeout: no result", i);
        continue;
      end
      checks++;
      if (r !== dv[i].er) begin
        errors++;
        $display("FAIL dir[%0d] result: got %h want %h",
                 i, r, dv[i].er);
      end
      checks++;
      if (f !== dv[i].ef) begin
        errors++;
        $display("FAIL dir[%0d] nzcv: got %b want %b",
                 i, f, dv[i].ef);
      end
      checks++;
      if (lat != dv[i].el) begin
        errors++;
        $display("FAIL dir[%0d] latency: got %0d want %0d",
                 i, lat, dv[i].el);
      end
    end
  endtask

  task automatic test_lsl_busy();
    bit to;
    alu_ctl = ALU_LSL;
    a = 64'd1;
    b = {$urandom, $urandom};
    shamt = 6'd3;
    in_valid = 1'b1;
    wait_ready(to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL lsl_busy ready: timeout");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0 ||
          out_valid !== 1'b0) begin
        errors++;
        $display("FAIL lsl_busy cyc%0d: busy=%b rdy=%b ov=%b want 1 0 0",
                 k, busy, in_ready, out_valid);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (out_valid !== 1'b1 || result !== 64'd8 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL lsl_busy done: ov=%b res=%h busy=%b want 1 8 0",
               out_valid, result, busy);
    end
  endtask

  task automatic test_random();
    logic [2:0] ctl;
    logic [63:0] x, y, r, er;
    logic [5:0] sh;
    logic [3:0] f, ef;
    int lat, el;
    bit to;
    for (int i = 0; i < 40; i++) begin
      ctl = 3'($urandom);
      x = {$urandom, $urandom};
      y = ($urandom_range(0, 3) == 0) ? x : {$urandom, $urandom};
      sh = 6'($urandom);
      model(ctl, x, y, sh, er, ef, el);
      run_op(ctl, x, y, sh, r, f, lat, to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL rnd[%0d] timeout: ctl=%b", i, ctl);
        continue;
      end
      checks++;
      if (r !== er || f !== ef || lat != el) begin
        errors++;
        $display("FAIL rnd[%0d] ctl=%b a=%h b=%h sh=%0d: got %h/%b/%0d want %h/%b/%0d",
                 i, ctl, x, y, sh, r, f, lat, er, ef, el);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] x, y, r0;
    logic [3:0] f0;
    bit to;
    out_ready = 1'b1;
    @(posedge clk); #1;
    wait_ready(to);
    out_ready = 1'b0;
    x = {$urandom, $urandom};
    y = {$urandom, $urandom};
    alu_ctl = ALU_ORR;
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    r0 = result;
    f0 = nzcv();
    checks++;
    if (out_valid !== 1'b1 || r0 !== (x | y)) begin
      errors++;
      $display("FAIL bp_orr: ov=%b res=%h want 1 %h",
               out_valid, r0, x | y);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (result !== r0 || nzcv() !== f0 ||
          out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: res=%h f=%b ov=%b rdy=%b want %h %b 1 0",
                 k, result, nzcv(), out_valid, in_ready, r0, f0);
      end
    end
    out_ready = 1'b1;
    alu_ctl = ALU_ADD;
    a = 64'd2;
    b = 64'd2;
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_rdy: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    checks++;
    if (out_valid !== 1'b1 || result !== 64'd4 ||
        nzcv() !== 4'b0000) begin
      errors++;
      $display("FAIL bp_add: ov=%b res=%h f=%b want 1 4 0000",
               out_valid, result, nzcv());
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ctl;
    logic [63:0] x, y, er;
    logic [5:0] sh;
    logic [3:0] ef;
    int el;
    bit to;
    out_ready = 1'b1;
    wait_ready(to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL b2b ready: timeout");
      return;
    end
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 6))
        0: ctl = ALU_AND;
        1: ctl = ALU_ORR;
        2: ctl = ALU_ADD;
        3: ctl = ALU_SUB;
        4: ctl = ALU_PASSB;
        5: ctl = ALU_LSL;
        default: ctl = ALU_LSR;
      endcase
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      sh = 6'($urandom_range(0, 1));
      model(ctl, x, y, sh, er, ef, el);
      alu_ctl = ctl;
      a = x;
      b = y;
      shamt = sh;
      in_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== er ||
          nzcv() !== ef || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b[%0d] ctl=%b: ov=%b res=%h f=%b rdy=%b want 1 %h %b 1",
                 i, ctl, out_valid, result, nzcv(), in_ready, er, ef);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    logic [63:0] r;
    logic [3:0] f;
    int lat, bad;
    bit to;
    run_op(ALU_PASSB, 64'd0, 64'h1234, 6'd0, r, f, lat, to);
    alu_ctl = ALU_MUL;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    in_valid = 1'b1;
    wait_ready(to);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    repeat (29) begin
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== 1'b1 || result !== 64'h1234) begin
      errors++;
      $display("FAIL rst_mul pre: busy=%b res=%h want 1 1234",
               busy, result);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 ||
        result !== 64'd0 || nzcv() !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mul abort: ov=%b busy=%b res=%h f=%b want 0 0 0 0000",
               out_valid, busy, result, nzcv());
    end
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_mul stale: %0d cycles with output, want 0",
               bad);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mul ready: got %b want 1", in_ready);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    alu_ctl = '0;
    a = '0;
    b = '0;
    shamt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_lsl_busy();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
